// File: rtl/snn_pkg.sv
// Shared constants and types for the SNN front end and core.
// The loader FSM state type lives here so checkers and the core can decode it.
package snn_pkg;

  localparam int NUM_PIXELS = 784;
  localparam int NUM_BYTES  = 98;
  localparam int PIX_ADDR_W = 10;

  // snn_core address widths
  localparam int CORE_INPUT_ADDR_W  = PIX_ADDR_W;
  localparam int CORE_NEURON_ADDR_W = 7;
  localparam int CORE_WEIGHT_ADDR_W = 17;

  localparam int BYTE_CNT_W = 7;
  localparam int BIT_CNT_W  = 3;

  typedef enum logic [1:0] {
    RECV   = 2'd0,
    UNPACK = 2'd1,
    START  = 2'd2,
    RUN    = 2'd3
  } loader_state_t;

endpackage

// File: rtl/ram_1w1r.sv
// Simple dual-access RAM: one write port, one registered read port.
// Reads beyond DEPTH return zero; array contents are never reset.
module ram_1w1r #(
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_WIDTH = 10,
  parameter int DEPTH      = 784
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_r;

  // Write port: storage only, no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we && (waddr < DEPTH_A)) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Registered read port with out-of-range addresses forced to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_r <= '0;
    end else if (raddr < DEPTH_A) begin
      rdata_r <= mem_r[raddr];
    end else begin
      rdata_r <= '0;
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/snn_input_loader.sv
// Receives a 98-byte packed binary image from the UART, unpacks it LSB first
// into a 784x1 pixel RAM, then pulses start and waits for snn_core's done.
module snn_input_loader #(
  parameter int NUM_PIXELS = snn_pkg::NUM_PIXELS,
  parameter int ADDR_W     = snn_pkg::PIX_ADDR_W,
  parameter int NUM_BYTES  = snn_pkg::NUM_BYTES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_rdy,
  input  logic [ADDR_W-1:0] addr_input_unit,
  output logic              q_input,
  output logic              start,
  input  logic              core_done,
  output logic              busy,
  output logic              overrun
);

  import snn_pkg::*;

  localparam logic [BYTE_CNT_W-1:0] LAST_BYTE = BYTE_CNT_W'(NUM_BYTES - 1);

  loader_state_t             state_r;
  loader_state_t             state_next_s;
  logic [7:0]                sr_r;
  logic [BYTE_CNT_W-1:0]     byte_cnt_r;
  logic [BIT_CNT_W-1:0]      bit_cnt_r;
  logic [ADDR_W-1:0]         wr_addr_r;
  logic                      start_r;
  logic                      busy_r;
  logic                      overrun_r;

  logic                      rx_accept_s;
  logic                      rx_drop_s;
  logic                      last_bit_s;
  logic                      last_byte_s;
  logic                      wr_en_s;
  logic                      wr_data_s;
  logic                      frame_first_s;

  assign rx_accept_s   = rx_rdy && (state_r == RECV);
  assign rx_drop_s     = rx_rdy && (state_r != RECV);
  assign frame_first_s = rx_accept_s && (byte_cnt_r == '0);
  assign wr_en_s       = (state_r == UNPACK);
  assign wr_data_s     = sr_r[bit_cnt_r];
  assign last_bit_s    = wr_en_s && (bit_cnt_r == 3'd7);
  assign last_byte_s   = last_bit_s && (byte_cnt_r == LAST_BYTE);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= RECV;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      RECV: begin
        if (rx_rdy) begin
          state_next_s = UNPACK;
        end else begin
          state_next_s = RECV;
        end
      end
      UNPACK: begin
        if (last_byte_s) begin
          state_next_s = START;
        end else if (last_bit_s) begin
          state_next_s = RECV;
        end else begin
          state_next_s = UNPACK;
        end
      end
      START: begin
        state_next_s = RUN;
      end
      RUN: begin
        if (core_done) begin
          state_next_s = RECV;
        end else begin
          state_next_s = RUN;
        end
      end
      default: begin
        state_next_s = RECV;
      end
    endcase
  end

  // Byte capture and unpack counters; wr_addr holds at 783 on the final bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_r       <= 8'h00;
      byte_cnt_r <= '0;
      bit_cnt_r  <= '0;
      wr_addr_r  <= '0;
    end else begin
      if (rx_accept_s) begin
        sr_r <= rx_data;
      end
      if (wr_en_s) begin
        bit_cnt_r <= bit_cnt_r + 3'd1;
        if (!last_byte_s) begin
          wr_addr_r <= wr_addr_r + ADDR_W'(1'b1);
        end
        if (last_bit_s) begin
          byte_cnt_r <= byte_cnt_r + 7'd1;
        end
      end else if (state_r == START) begin
        byte_cnt_r <= '0;
        wr_addr_r  <= '0;
      end
    end
  end

  // Registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_r   <= 1'b0;
      busy_r    <= 1'b0;
      overrun_r <= 1'b0;
    end else begin
      start_r <= (state_next_s == START);
      if (frame_first_s) begin
        busy_r <= 1'b1;
      end else if ((state_r == RUN) && core_done) begin
        busy_r <= 1'b0;
      end
      if (rx_drop_s) begin
        overrun_r <= 1'b1;
      end else if (frame_first_s) begin
        overrun_r <= 1'b0;
      end
    end
  end

  ram_1w1r #(
    .DATA_WIDTH (1),
    .ADDR_WIDTH (ADDR_W),
    .DEPTH      (NUM_PIXELS)
  ) u_pixel_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wr_en_s),
    .waddr (wr_addr_r),
    .wdata (wr_data_s),
    .raddr (addr_input_unit),
    .rdata (q_input)
  );

  assign start   = start_r;
  assign busy    = busy_r;
  assign overrun = overrun_r;

endmodule

// File: tb/tb_snn_input_loader.sv
// Directed self-checking bench for snn_input_loader.
module tb_snn_input_loader;

  logic       clk;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_rdy;
  logic [9:0] addr_input_unit;
  logic       q_input;
  logic       start;
  logic       core_done;
  logic       busy;
  logic       overrun;

  int n_pass;
  int n_total;
  int start_cnt;
  int start_ref;
  logic [7:0] frm [98];
  logic [7:0] bv;

  snn_input_loader dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .rx_data         (rx_data),
    .rx_rdy          (rx_rdy),
    .addr_input_unit (addr_input_unit),
    .q_input         (q_input),
    .start           (start),
    .core_done       (core_done),
    .busy            (busy),
    .overrun         (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (start === 1'b1) start_cnt <= start_cnt + 1;
  end

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    @(negedge clk);
    rx_data = b;
    rx_rdy  = 1'b1;
    @(posedge clk);
    #1;
    rx_rdy = 1'b0;
    repeat (gap - 1) @(posedge clk);
  endtask

  task automatic send_range(input int lo, input int hi);
    for (int i = lo; i < hi; i++) send(frm[i], 12);
  endtask

  // Final byte: start must rise exactly after the 8th write edge, for one cycle.
  task automatic last_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_rdy  = 1'b1;
    @(posedge clk);
    #1;
    rx_rdy = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("start_lat_k%0d", k), start, (k == 8));
    end
  endtask

  task automatic rd(input int a, input logic exp, input string tag);
    @(negedge clk);
    addr_input_unit = 10'(a);
    @(posedge clk);
    #1;
    chk($sformatf("%s_a%0d", tag, a), q_input, exp);
  endtask

  task automatic pulse_done();
    @(negedge clk);
    core_done = 1'b1;
    @(posedge clk);
    #1;
    core_done = 1'b0;
  endtask

  initial begin
    n_pass = 0; n_total = 0; start_cnt = 0;
    rst_n = 1'b0; rx_data = 8'h00; rx_rdy = 1'b0;
    addr_input_unit = 10'd0; core_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_start", start, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_overrun", overrun, 1'b0);
    chk("rst_q", q_input, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Frame 1: all 0xA5
    for (int i = 0; i < 98; i++) frm[i] = 8'hA5;
    send(frm[0], 1);
    chk("f1_busy_first", busy, 1'b1);
    chk("f1_overrun_first", overrun, 1'b0);
    repeat (10) @(posedge clk);
    send_range(1, 97);
    chk("f1_no_early_start", (start_cnt == 0), 1'b1);
    last_byte(frm[97]);
    chk("f1_start_once", (start_cnt == 1), 1'b1);
    bv = 8'hA5;
    for (int p = 0; p < 784; p++) rd(p, bv[p % 8], "f1_pix");
    rd(784, 1'b0, "oob");
    rd(1023, 1'b0, "oob");
    chk("f1_busy_run", busy, 1'b1);

    // Byte during RUN: flagged, dropped, no state change
    send(8'hFF, 12);
    chk("run_rx_overrun", overrun, 1'b1);
    chk("run_rx_busy", busy, 1'b1);
    chk("run_rx_no_start", (start_cnt == 1), 1'b1);
    for (int p = 0; p < 8; p++) rd(p, bv[p % 8], "run_rx_pix");
    pulse_done();
    chk("f1_done_busy", busy, 1'b0);
    chk("f1_done_overrun_sticky", overrun, 1'b1);

    // Frame 2: only pixels 0 and 783 set; core_done mid-frame is ignored
    for (int i = 0; i < 98; i++) frm[i] = 8'h00;
    frm[0]  = 8'h01;
    frm[97] = 8'h80;
    send(frm[0], 12);
    chk("f2_overrun_cleared", overrun, 1'b0);
    chk("f2_busy", busy, 1'b1);
    send_range(1, 10);
    pulse_done();
    chk("recv_done_ignored", busy, 1'b1);
    repeat (5) @(posedge clk);
    send_range(10, 97);
    last_byte(frm[97]);
    chk("f2_start_once", (start_cnt == 2), 1'b1);
    rd(0, 1'b1, "f2_pix");
    rd(783, 1'b1, "f2_pix");
    for (int p = 1; p < 783; p++) rd(p, 1'b0, "f2_pix");
    pulse_done();
    chk("f2_done_busy", busy, 1'b0);

    // Frame 3: second rx_rdy 4 cycles after the first is dropped
    for (int i = 0; i < 98; i++) frm[i] = 8'h0F;
    frm[0] = 8'hFF;
    send(frm[0], 4);
    send(8'h00, 12);
    chk("close_rx_overrun", overrun, 1'b1);
    send_range(1, 97);
    chk("close_rx_no_early_start", (start_cnt == 2), 1'b1);
    last_byte(frm[97]);
    chk("close_rx_start", (start_cnt == 3), 1'b1);
    chk("close_rx_overrun_sticky", overrun, 1'b1);
    for (int p = 0; p < 784; p++) begin
      bv = frm[p / 8];
      rd(p, bv[p % 8], "f3_pix");
    end
    pulse_done();

    // Reset after 50 bytes, then a fresh full frame
    for (int i = 0; i < 50; i++) send(8'hFF, 12);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_overrun", overrun, 1'b0);
    rst_n = 1'b1;
    start_ref = start_cnt;
    for (int i = 0; i < 98; i++) frm[i] = 8'(i);
    send_range(0, 97);
    chk("midrst_no_early_start", (start_cnt == start_ref), 1'b1);
    last_byte(frm[97]);
    chk("midrst_start", (start_cnt == start_ref + 1), 1'b1);
    for (int p = 0; p < 784; p++) begin
      bv = frm[p / 8];
      rd(p, bv[p % 8], "f4_pix");
    end
    pulse_done();
    chk("f4_done_busy", busy, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
